// File: rtl/mc_datapath_pkg.sv
// rtl/mc_datapath_pkg.sv - opcodes, ALU codes, FSM states and control-word decode for mc_datapath
package mc_datapath_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b101;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [2:0] {S_IDLE, S_DECODE, S_EXEC, S_MEM, S_WB} state_t;

  typedef struct packed {
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src;
    logic [2:0] alu_ctrl;
    logic       mem_write;
    logic       mem_read;
    logic       mem_to_reg;
    logic       branch;
  } ctrl_t;

  function automatic logic is_legal(input logic [31:0] inst);
    logic ok;
    ok = 1'b0;
    case (inst[31:26])
      OP_RTYPE: ok = (inst[5:0] == FN_ADD) || (inst[5:0] == FN_SUB) || (inst[5:0] == FN_AND) ||
                     (inst[5:0] == FN_OR)  || (inst[5:0] == FN_SLT);
      OP_LW, OP_SW, OP_ADDI, OP_BEQ: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic ctrl_t decode(input logic [31:0] inst);
    ctrl_t c;
    c = '0;
    c.alu_ctrl = ALU_ADD;
    case (inst[31:26])
      OP_RTYPE: begin
        c.reg_dst   = 1'b1;
        c.reg_write = 1'b1;
        case (inst[5:0])
          FN_SUB:  c.alu_ctrl = ALU_SUB;
          FN_AND:  c.alu_ctrl = ALU_AND;
          FN_OR:   c.alu_ctrl = ALU_OR;
          FN_SLT:  c.alu_ctrl = ALU_SLT;
          default: c.alu_ctrl = ALU_ADD;
        endcase
      end
      OP_LW: begin
        c.alu_src    = 1'b1;
        c.mem_read   = 1'b1;
        c.mem_to_reg = 1'b1;
        c.reg_write  = 1'b1;
      end
      OP_SW: begin
        c.alu_src   = 1'b1;
        c.mem_write = 1'b1;
      end
      OP_ADDI: begin
        c.alu_src   = 1'b1;
        c.reg_write = 1'b1;
      end
      OP_BEQ: begin
        c.branch   = 1'b1;
        c.alu_ctrl = ALU_SUB;
      end
      default: c = c;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mc_datapath_regfile.sv
// rtl/mc_datapath_regfile.sv - mc_regfile: 2 async read ports, 1 sync write port, register 0 reads 0
module mc_regfile #(
  parameter int DATA_W  = 32,
  parameter int REG_CNT = 32,
  parameter int AW      = $clog2(REG_CNT)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [AW-1:0]     ra1,
  input  logic [AW-1:0]     ra2,
  input  logic              we,
  input  logic [AW-1:0]     wa,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2
);

  logic [DATA_W-1:0] regs [REG_CNT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_CNT; i++) regs[i] <= '0;
    end else if (we && (wa != '0)) begin
      regs[wa] <= wdata;
    end
  end

  assign rdata1 = (ra1 == '0) ? '0 : regs[ra1];
  assign rdata2 = (ra2 == '0) ? '0 : regs[ra2];

endmodule

// File: rtl/mc_datapath.sv
// rtl/mc_datapath.sv - multi-cycle MIPS-subset datapath with internal control FSM
// Optional cycle/instruction counters when MC_DATAPATH_PERF_EN is defined.
module mc_datapath
  import mc_datapath_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_CNT    = 32,
  parameter int DMEM_DEPTH = 64,
  parameter int PC_W       = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [PC_W-1:0]   pc,
  input  logic [31:0]       inst,
  input  logic              inst_valid,
  output logic              inst_ready,
  output logic [DATA_W-1:0] rd,
  output logic              done,
  output logic              illegal,
  output logic              busy
`ifdef MC_DATAPATH_PERF_EN
  ,
  output logic [31:0]       perf_cycles,
  output logic [31:0]       perf_insts
`endif
);

  localparam int RAW = $clog2(REG_CNT);
  localparam int MAW = $clog2(DMEM_DEPTH);

  state_t            state, state_nx;
  logic [31:0]       ir;
  logic [DATA_W-1:0] a_q, b_q, alu_q, mdr_q;
  logic [DATA_W-1:0] rf_r1, rf_r2, simm, op2, alu_res, wb_data;
  logic [PC_W-1:0]   br_off, pc_nx;
  logic [RAW-1:0]    wa;
  logic [MAW-1:0]    mem_idx;
  ctrl_t             ctrl;
  logic              legal;
  logic              ld_ir, ld_ab, ld_alu, ld_mdr, mem_we, reg_we, pc_we;
  logic [DATA_W-1:0] dmem [DMEM_DEPTH];

  assign ctrl    = decode(ir);
  assign legal   = is_legal(ir);
  assign simm    = DATA_W'($signed(ir[15:0]));
  assign br_off  = PC_W'($signed(ir[15:0])) << 2;
  assign op2     = ctrl.alu_src ? simm : b_q;
  assign wa      = ctrl.reg_dst ? ir[11 +: RAW] : ir[16 +: RAW];
  assign wb_data = ctrl.mem_to_reg ? mdr_q : alu_q;
  assign mem_idx = alu_q[MAW+1:2];
  assign busy    = (state != S_IDLE);

  mc_regfile #(.DATA_W(DATA_W), .REG_CNT(REG_CNT), .AW(RAW)) u_regfile (
    .clk   (clk),
    .rst_n (rst_n),
    .ra1   (ir[21 +: RAW]),
    .ra2   (ir[16 +: RAW]),
    .we    (reg_we),
    .wa    (wa),
    .wdata (wb_data),
    .rdata1(rf_r1),
    .rdata2(rf_r2)
  );

  always_comb begin
    alu_res = '0;
    case (ctrl.alu_ctrl)
      ALU_AND: alu_res = a_q & op2;
      ALU_OR:  alu_res = a_q | op2;
      ALU_ADD: alu_res = a_q + op2;
      ALU_SUB: alu_res = a_q - op2;
      ALU_SLT: alu_res = DATA_W'($signed(a_q) < $signed(op2));
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    inst_ready = 1'b0;
    done       = 1'b0;
    illegal    = 1'b0;
    ld_ir      = 1'b0;
    ld_ab      = 1'b0;
    ld_alu     = 1'b0;
    ld_mdr     = 1'b0;
    mem_we     = 1'b0;
    reg_we     = 1'b0;
    pc_we      = 1'b0;
    pc_nx      = pc + PC_W'(4);
    case (state)
      S_IDLE: begin
        inst_ready = 1'b1;
        if (inst_valid) begin
          ld_ir    = 1'b1;
          state_nx = S_DECODE;
        end
      end
      S_DECODE: begin
        if (!legal) begin
          illegal  = 1'b1;
          pc_we    = 1'b1;
          state_nx = S_IDLE;
        end else begin
          ld_ab    = 1'b1;
          state_nx = S_EXEC;
        end
      end
      S_EXEC: begin
        ld_alu = 1'b1;
        if (ctrl.branch) begin
          done     = 1'b1;
          pc_we    = 1'b1;
          state_nx = S_IDLE;
          if (a_q == b_q) pc_nx = pc + PC_W'(4) + br_off;
        end else if (ctrl.mem_read || ctrl.mem_write) begin
          state_nx = S_MEM;
        end else begin
          state_nx = S_WB;
        end
      end
      S_MEM: begin
        if (ctrl.mem_write) begin
          mem_we   = 1'b1;
          done     = 1'b1;
          pc_we    = 1'b1;
          state_nx = S_IDLE;
        end else begin
          ld_mdr   = 1'b1;
          state_nx = S_WB;
        end
      end
      S_WB: begin
        reg_we   = ctrl.reg_write;
        done     = 1'b1;
        pc_we    = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir    <= '0;
      a_q   <= '0;
      b_q   <= '0;
      alu_q <= '0;
      mdr_q <= '0;
      pc    <= '0;
      rd    <= '0;
    end else begin
      if (ld_ir)  ir    <= inst;
      if (ld_ab)  begin a_q <= rf_r1; b_q <= rf_r2; end
      if (ld_alu) alu_q <= alu_res;
      if (ld_mdr) mdr_q <= dmem[mem_idx];
      if (pc_we)  pc    <= pc_nx;
      if (reg_we) rd    <= wb_data;
    end
  end

  // Data memory has no reset; a store only fires from the MEM state, which reset leaves.
  always_ff @(posedge clk) begin
    if (mem_we) dmem[mem_idx] <= b_q;
  end

`ifdef MC_DATAPATH_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_cycles <= '0;
      perf_insts  <= '0;
    end else begin
      if (busy && (perf_cycles != '1)) perf_cycles <= perf_cycles + 32'd1;
      if (done && (perf_insts != '1))  perf_insts  <= perf_insts + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mc_datapath.sv
// tb/tb_mc_datapath.sv - self-checking bench for mc_datapath: vector table, random vs model, reset cases
module tb_mc_datapath;

  localparam int DW = 32;
  localparam int RC = 16;
  localparam int DD = 16;
  localparam int PW = 32;
  localparam int NV = 22;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [PW-1:0] pc;
  logic [31:0]   inst;
  logic          inst_valid, inst_ready;
  logic [DW-1:0] rd;
  logic          done, illegal, busy;

  always #5 clk = ~clk;

  mc_datapath #(.DATA_W(DW), .REG_CNT(RC), .DMEM_DEPTH(DD), .PC_W(PW)) dut (
    .clk(clk), .rst_n(rst_n), .pc(pc), .inst(inst), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .rd(rd), .done(done), .illegal(illegal), .busy(busy)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] m_regs [RC];
  logic [31:0] m_mem  [DD];
  logic [31:0] m_pc, m_rd;
  bit          m_rd_known;

  typedef struct {
    logic [31:0] inst;
    int          lat;
    bit          ill;
    bit          rd_chk;
    logic [31:0] rd;
    logic [31:0] pc;
  } vec_t;

  vec_t vecs [NV];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < RC; k++) m_regs[k] = '0;
    m_pc = '0;
    m_rd = '0;
    m_rd_known = 1'b1;
  endtask

  // Architectural effect of one instruction; returns expected accept-to-done latency.
  task automatic model_step(input logic [31:0] i, output int lat, output bit ill);
    int rs, rt, rdf, dst;
    logic [31:0] a, b, simm, res, addr, nxt;
    bit wr;
    rs = int'(i[25:21]) % RC;
    rt = int'(i[20:16]) % RC;
    rdf = int'(i[15:11]) % RC;
    a = m_regs[rs];
    b = m_regs[rt];
    simm = {{16{i[15]}}, i[15:0]};
    addr = a + simm;
    ill = 1'b0; wr = 1'b0; lat = 0; dst = 0; res = '0;
    nxt = m_pc + 32'd4;
    case (i[31:26])
      6'h00: begin
        lat = 4; wr = 1'b1; dst = rdf;
        case (i[5:0])
          6'h20: res = a + b;
          6'h22: res = a - b;
          6'h24: res = a & b;
          6'h25: res = a | b;
          6'h2A: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          default: begin ill = 1'b1; wr = 1'b0; end
        endcase
      end
      6'h08: begin lat = 4; wr = 1'b1; dst = rt; res = addr; end
      6'h23: begin lat = 5; wr = 1'b1; dst = rt; res = m_mem[(addr >> 2) % DD]; end
      6'h2B: begin lat = 4; m_mem[(addr >> 2) % DD] = b; end
      6'h04: begin lat = 3; if (a == b) nxt = m_pc + 32'd4 + (simm << 2); end
      default: ill = 1'b1;
    endcase
    if (ill) lat = 2;
    if (wr) begin
      if (dst != 0) begin
        m_regs[dst] = res;
        m_rd = res;
        m_rd_known = 1'b1;
      end else begin
        m_rd_known = 1'b0;
      end
    end
    m_pc = nxt;
  endtask

  // Called at a falling edge with the DUT idle; returns at the falling edge after completion.
  task automatic run(input logic [31:0] i, output int lat, output bit got_done, output bit got_ill);
    lat = 0; got_done = 1'b0; got_ill = 1'b0;
    inst = i;
    inst_valid = 1'b1;
    @(negedge clk);
    inst_valid = 1'b0;
    inst = $urandom;
    for (int c = 2; c <= 8; c++) begin
      if (done || illegal) begin
        lat = c; got_done = done; got_ill = illegal;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic step(input logic [31:0] i, input string tag);
    int lat, elat;
    bit gd, gi, eill;
    run(i, lat, gd, gi);
    model_step(i, elat, eill);
    chk($sformatf("%s lat %08h", tag, i), 64'(lat), 64'(elat));
    chk($sformatf("%s illegal %08h", tag, i), 64'(gi), 64'(eill));
    chk($sformatf("%s done %08h", tag, i), 64'(gd), 64'(!eill));
    chk($sformatf("%s pc %08h", tag, i), 64'(pc), 64'(m_pc));
    if (m_rd_known) chk($sformatf("%s rd %08h", tag, i), 64'(rd), 64'(m_rd));
  endtask

  function automatic logic [31:0] rand_inst();
    logic [5:0] fl [5];
    logic [4:0] rs, rt, rdf;
    logic [15:0] imm;
    int k;
    fl = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    rs = 5'($urandom_range(0, 31));
    rt = 5'($urandom_range(0, 31));
    rdf = 5'($urandom_range(0, 31));
    imm = 16'($urandom);
    k = $urandom_range(0, 9);
    case (k)
      0, 1, 2, 3: return {6'h00, rs, rt, rdf, 5'd0, fl[$urandom_range(0, 4)]};
      4, 9:       return {6'h08, rs, rt, imm};
      5:          return {6'h23, rs, rt, imm};
      6:          return {6'h2B, rs, rt, imm};
      7:          return {6'h04, rs, ($urandom_range(0, 1) != 0) ? rs : rt, imm};
      default:    return ($urandom_range(0, 1) != 0) ? {6'h3F, rs, rt, imm}
                                                     : {6'h00, rs, rt, rdf, 5'd0, 6'h21};
    endcase
  endfunction

  initial begin
    int lat, elat;
    bit gd, gi, eill;

    vecs[0]  = '{32'h20020005, 4, 1'b0, 1'b1, 32'd5,          32'd4};
    vecs[1]  = '{32'h20030007, 4, 1'b0, 1'b1, 32'd7,          32'd8};
    vecs[2]  = '{32'h00430820, 4, 1'b0, 1'b1, 32'd12,         32'd12};
    vecs[3]  = '{32'hAC410000, 4, 1'b0, 1'b1, 32'd12,         32'd16};
    vecs[4]  = '{32'h8C440000, 5, 1'b0, 1'b1, 32'd12,         32'd20};
    vecs[5]  = '{32'h8C060004, 5, 1'b0, 1'b1, 32'd12,         32'd24};
    vecs[6]  = '{32'h8C070104, 5, 1'b0, 1'b1, 32'd12,         32'd28};
    vecs[7]  = '{32'h10240003, 3, 1'b0, 1'b1, 32'd12,         32'd44};
    vecs[8]  = '{32'h20040000, 4, 1'b0, 1'b1, 32'd0,          32'd48};
    vecs[9]  = '{32'h10240003, 3, 1'b0, 1'b1, 32'd0,          32'd52};
    vecs[10] = '{32'hFC000000, 2, 1'b1, 1'b1, 32'd0,          32'd56};
    vecs[11] = '{32'h00274020, 4, 1'b0, 1'b1, 32'd24,         32'd60};
    vecs[12] = '{32'h00434822, 4, 1'b0, 1'b1, 32'hFFFFFFFE,   32'd64};
    vecs[13] = '{32'h0122502A, 4, 1'b0, 1'b1, 32'd1,          32'd68};
    vecs[14] = '{32'h00235824, 4, 1'b0, 1'b1, 32'd4,          32'd72};
    vecs[15] = '{32'h00236025, 4, 1'b0, 1'b1, 32'd15,         32'd76};
    vecs[16] = '{32'h20000009, 4, 1'b0, 1'b0, 32'd0,          32'd80};
    vecs[17] = '{32'h00006820, 4, 1'b0, 1'b1, 32'd0,          32'd84};
    vecs[18] = '{32'h20110003, 4, 1'b0, 1'b1, 32'd3,          32'd88};
    vecs[19] = '{32'h00207020, 4, 1'b0, 1'b1, 32'd3,          32'd92};
    vecs[20] = '{32'h00000000, 2, 1'b1, 1'b1, 32'd3,          32'd96};
    vecs[21] = '{32'h0049782A, 4, 1'b0, 1'b1, 32'd0,          32'd100};

    rst_n = 1'b0;
    inst = '0;
    inst_valid = 1'b0;
    for (int k = 0; k < DD; k++) m_mem[k] = '0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset pc", 64'(pc), 64'd0);
    chk("reset rd", 64'(rd), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset illegal", 64'(illegal), 64'd0);
    chk("reset inst_ready", 64'(inst_ready), 64'd1);
    chk("reset busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int k = 0; k < NV; k++) begin
      run(vecs[k].inst, lat, gd, gi);
      model_step(vecs[k].inst, elat, eill);
      chk($sformatf("vec%0d lat", k), 64'(lat), 64'(vecs[k].lat));
      chk($sformatf("vec%0d illegal", k), 64'(gi), 64'(vecs[k].ill));
      chk($sformatf("vec%0d done", k), 64'(gd), 64'(!vecs[k].ill));
      chk($sformatf("vec%0d pc", k), 64'(pc), 64'(vecs[k].pc));
      if (vecs[k].rd_chk) chk($sformatf("vec%0d rd", k), 64'(rd), 64'(vecs[k].rd));
    end

    for (int k = 0; k < DD; k++) step({6'h2B, 5'd0, 5'd0, 16'(k * 4)}, "init");
    for (int k = 0; k < 300; k++) step(rand_inst(), "rand");

    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    step(32'h20020005, "pre");
    step(32'h20030007, "pre");
    inst = 32'h00430820;
    inst_valid = 1'b1;
    @(negedge clk);
    inst_valid = 1'b0;
    @(negedge clk);
    chk("midop busy before reset", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("midop pc", 64'(pc), 64'd0);
    chk("midop busy", 64'(busy), 64'd0);
    chk("midop inst_ready", 64'(inst_ready), 64'd1);
    chk("midop done", 64'(done), 64'd0);
    chk("midop rd", 64'(rd), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    step(32'h00202820, "post");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
